uart_tx_gen: RTL and testbench
==============================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, bitclk cycles per bit-time, legal range 1..65535.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 1 selects odd parity and 0 selects even; it is ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bit-times, legal values 1 or 2.
REQ-006 SHALL have parameter GUARD_BITS, default 4, idle bit-times after stop with bsy held high, legal range 0..15.
REQ-007 SHALL have port bitclk, input, 1 bit, the single module clock.
REQ-008 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1 bit, transmit request.
REQ-010 SHALL have port data, input, DATA_W bits, frame payload.
REQ-011 SHALL have port bsy, output, 1 bit, frame in progress.
REQ-012 SHALL have port done, output, 1 bit, single-cycle pulse at end of frame.
REQ-013 SHALL have port txline, output, 1 bit, serial line, idle high.
REQ-014 SHALL have port dbg_state, output, 3 bits, current FSM state encoding.
REQ-015 SHALL have port dbg_bitcnt, output, 4 bits, current bit index within DATA or STOP or GUARD.

Function
REQ-016 SHALL implement FSM states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, GUARD=5, with all other codes returning to IDLE.
REQ-017 SHALL accept a request only when start=1 and bsy=0 at a rising bitclk edge, latching data into a DATA_W-bit shift register and the parity bit (XOR of data, inverted if PARITY_ODD).
REQ-018 SHALL, on acceptance, drive txline=0 and bsy=1 from the next cycle, so the accept-to-start-bit latency is 1 cycle.
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-time counter that reloads on every state or bit change.
REQ-020 SHALL follow the sequence START (1 bit), DATA (DATA_W bits, LSB first), PARITY (1 bit, only if PARITY_EN), STOP (STOP_BITS bits, txline=1), GUARD (GUARD_BITS bit-times, txline=1), and skip GUARD when GUARD_BITS=0.
REQ-021 SHALL keep bsy=1 for exactly (1+DATA_W+PARITY_EN+STOP_BITS+GUARD_BITS)*CLKS_PER_BIT cycles.
REQ-022 SHALL pulse done=1 for one cycle, concurrent with bsy falling to 0.
REQ-023 SHALL ignore start while bsy=1, with no effect on the shift register or the frame.
REQ-024 SHALL ignore changes to data after acceptance, transmitting the latched value.
REQ-025 SHALL accept a start held high continuously on the first cycle with bsy=0, giving back-to-back frames separated by exactly 1 idle cycle (txline=1).
REQ-026 SHALL handle CLKS_PER_BIT=1 as one bit per cycle, with no zero-length bit and no counter underflow.
REQ-027 SHALL drive txline=1 in IDLE at all times.

Reset
REQ-028 SHALL, when reset=1 at a rising bitclk edge, set state=IDLE, txline=1, bsy=0, done=0, shift register=0, counters=0, and dbg outputs=0.
REQ-029 SHALL let reset mid-frame abort the frame within 1 cycle: txline returns to 1 and no done pulse is issued.
REQ-030 SHALL give reset priority over start asserted in the same cycle.

Structure
REQ-031 SHALL place the state encoding constants and a frame-length function (bits per frame from the parameters) in the shared package uart_pkg.
REQ-032 SHALL implement the bit-time divider as sub-module uart_baud_tick (parameter CLKS_PER_BIT; inputs clear and enable; output tick).
REQ-033 SHALL make illegal parameter values a elaboration-time error.

Verification
REQ-034 SHALL cover: defaults, data=0xA5, start for 1 cycle -> txline 0,1,0,1,0,0,1,0,1,1 on the following cycles; bsy high for 14 cycles; done pulses on cycle 14.
REQ-035 SHALL cover: PARITY_EN=1, PARITY_ODD=0, data=0xA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; bsy high for 15 cycles.
REQ-036 SHALL cover: CLKS_PER_BIT=4, STOP_BITS=2, GUARD_BITS=0, data=0x01 -> start low for 4 cycles; data bit0 high for 4 cycles; bits 1..7 low for 28 cycles; stop high for 8 cycles; bsy=44 cycles.
REQ-037 SHALL cover: start held high, data=0x55 then 0x0F -> two frames, second start bit 1 cycle after first bsy falls; second frame carries 0x0F; start pulses mid-frame ignored.
REQ-038 SHALL cover: reset asserted during DATA bit 3 -> next cycle txline=1, bsy=0, done never pulses; a subsequent start sends a full correct frame.
REQ-039 SHALL cover: DATA_W=5, data=5'h1B -> txline 0,1,1,0,1,1,1 followed by 4 guard bit-times; bsy=11 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit generator: FSM state codes and frame sizing.
package uart_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned BITCNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GUARD  = 3'd5
    } tx_state_e;

    // Bit-times in one frame, guard interval included.
    function automatic int unsigned frame_bits(
        input int unsigned data_w,
        input int unsigned parity_en,
        input int unsigned stop_bits,
        input int unsigned guard_bits
    );
        return 1 + data_w + parity_en + stop_bits + guard_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: tick marks the last bitclk cycle of each bit-time.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic bitclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge bitclk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop and guard bit-times.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned GUARD_BITS   = 4
) (
    input  logic                bitclk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   data,
    output logic                bsy,
    output logic                done,
    output logic                txline,
    output logic [STATE_W-1:0]  dbg_state,
    output logic [BITCNT_W-1:0] dbg_bitcnt
);

    localparam logic [BITCNT_W-1:0] LAST_DATA  = BITCNT_W'(DATA_W - 1);
    localparam logic [BITCNT_W-1:0] LAST_STOP  = BITCNT_W'(STOP_BITS - 1);
    localparam logic [BITCNT_W-1:0] LAST_GUARD = BITCNT_W'((GUARD_BITS == 0) ? 0 : GUARD_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_gen: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx_gen: CLKS_PER_BIT must be 1..65535");
    end
    if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx_gen: PARITY_EN and PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_gen: STOP_BITS must be 1 or 2");
    end
    if (GUARD_BITS > 15) begin : g_bad_guard
        $error("uart_tx_gen: GUARD_BITS must be 0..15");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic                 bsy_q, bsy_d;
    logic                 done_q, done_d;
    logic                 tx_q, tx_d;
    logic                 tick;

    // Divider is held cleared while idle so every frame starts a fresh bit-time.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .bitclk (bitclk),
        .reset  (reset),
        .clear  (state_q == ST_IDLE),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    always_ff @(posedge bitclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            bitcnt_q <= '0;
            bsy_q    <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            bitcnt_q <= bitcnt_d;
            bsy_q    <= bsy_d;
            done_q   <= done_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_START;
                    shreg_d  = data;
                    par_d    = (^data) ^ 1'(PARITY_ODD);
                    bitcnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d  = ST_STOP;
                    bitcnt_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bitcnt_q == LAST_STOP) begin
                        bitcnt_d = '0;
                        if (GUARD_BITS != 0) begin
                            state_d = ST_GUARD;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (tick) begin
                    if (bitcnt_q == LAST_GUARD) begin
                        bitcnt_d = '0;
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bitcnt_d = '0;
            end
        endcase

        // Line level is computed from the next state so txline is a plain flop.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        bsy_d = (state_d != ST_IDLE);
    end

    assign bsy        = bsy_q;
    assign done       = done_q;
    assign txline     = tx_q;
    assign dbg_state  = state_q;
    assign dbg_bitcnt = bitcnt_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen across five parameter sets sharing one clock and reset.
module tb_uart_tx_gen;

    logic       bitclk = 1'b0;
    logic       reset;
    logic [4:0] start_r;
    logic [7:0] data_b;

    wire [4:0] bsy_w;
    wire [4:0] done_w;
    wire [4:0] tx_w;
    wire [2:0] st_w [5];
    wire [3:0] bc_w [5];

    int    n_vec = 0;
    int    n_bad = 0;
    string cur   = "reset";

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] data;
        string      exp;
        int         cpb;
    } vec_t;

    vec_t vecs [9];

    always #5 bitclk = ~bitclk;

    // 0: defaults
    uart_tx_gen u_def (
        .bitclk(bitclk), .reset(reset), .start(start_r[0]), .data(data_b),
        .bsy(bsy_w[0]), .done(done_w[0]), .txline(tx_w[0]),
        .dbg_state(st_w[0]), .dbg_bitcnt(bc_w[0])
    );

    // 1: even parity
    uart_tx_gen #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
        .bitclk(bitclk), .reset(reset), .start(start_r[1]), .data(data_b),
        .bsy(bsy_w[1]), .done(done_w[1]), .txline(tx_w[1]),
        .dbg_state(st_w[1]), .dbg_bitcnt(bc_w[1])
    );

    // 2: odd parity
    uart_tx_gen #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
        .bitclk(bitclk), .reset(reset), .start(start_r[2]), .data(data_b),
        .bsy(bsy_w[2]), .done(done_w[2]), .txline(tx_w[2]),
        .dbg_state(st_w[2]), .dbg_bitcnt(bc_w[2])
    );

    // 3: slow bit rate, two stop bits, no guard
    uart_tx_gen #(.CLKS_PER_BIT(4), .STOP_BITS(2), .GUARD_BITS(0)) u_slow (
        .bitclk(bitclk), .reset(reset), .start(start_r[3]), .data(data_b),
        .bsy(bsy_w[3]), .done(done_w[3]), .txline(tx_w[3]),
        .dbg_state(st_w[3]), .dbg_bitcnt(bc_w[3])
    );

    // 4: five data bits
    uart_tx_gen #(.DATA_W(5)) u_w5 (
        .bitclk(bitclk), .reset(reset), .start(start_r[4]), .data(data_b[4:0]),
        .bsy(bsy_w[4]), .done(done_w[4]), .txline(tx_w[4]),
        .dbg_state(st_w[4]), .dbg_bitcnt(bc_w[4])
    );

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", cur, what, act, exp, $time);
        end
    endtask

    task automatic check_idle(input int sel, input logic exp_done);
        check("idle_bsy", 32'(bsy_w[sel]), 0);
        check("idle_done", 32'(done_w[sel]), 32'(exp_done));
        check("idle_tx", 32'(tx_w[sel]), 1);
        check("idle_state", 32'(st_w[sel]), 0);
        check("idle_bitcnt", 32'(bc_w[sel]), 0);
    endtask

    // Entered at the negedge of frame cycle 1; leaves at the negedge of the idle cycle after bsy falls.
    task automatic check_frame(input int sel, input string exp, input int cpb, input bit pulse);
        int k = 0;
        for (int i = 0; i < exp.len(); i++) begin
            for (int c = 0; c < cpb; c++) begin
                check("tx", 32'(tx_w[sel]), 32'(exp[i] == 8'h31));
                check("bsy", 32'(bsy_w[sel]), 1);
                check("done_early", 32'(done_w[sel]), 0);
                if (k == 0) check("state_start", 32'(st_w[sel]), 1);
                if (pulse) start_r[sel] = (k == 1 || k == 2);
                k++;
                @(negedge bitclk);
            end
        end
        check_idle(sel, 1'b1);
    endtask

    task automatic run_frame(input int sel, input logic [7:0] d, input string exp, input int cpb);
        data_b       = d;
        start_r[sel] = 1'b1;
        @(negedge bitclk);
        start_r[sel] = 1'b0;
        data_b       = ~d;
        check_frame(sel, exp, cpb, 1'b1);
        @(negedge bitclk);
        check_idle(sel, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"def_A5",    0, 8'hA5, "01010010111111",  1};
        vecs[1] = '{"def_00",    0, 8'h00, "00000000011111",  1};
        vecs[2] = '{"def_FF",    0, 8'hFF, "01111111111111",  1};
        vecs[3] = '{"even_A5",   1, 8'hA5, "010100101011111", 1};
        vecs[4] = '{"odd_A5",    2, 8'hA5, "010100101111111", 1};
        vecs[5] = '{"even_01",   1, 8'h01, "010000000111111", 1};
        vecs[6] = '{"slow_01",   3, 8'h01, "01000000011",     4};
        vecs[7] = '{"w5_1B",     4, 8'h1B, "01101111111",     1};
        vecs[8] = '{"w5_00",     4, 8'h00, "00000011111",     1};

        reset   = 1'b1;
        start_r = '0;
        data_b  = '0;
        repeat (2) @(negedge bitclk);
        for (int s = 0; s < 5; s++) check_idle(s, 1'b0);
        reset = 1'b0;
        @(negedge bitclk);

        // Reset wins over a simultaneous start.
        cur        = "reset_vs_start";
        reset      = 1'b1;
        start_r[0] = 1'b1;
        data_b     = 8'hA5;
        @(negedge bitclk);
        check_idle(0, 1'b0);
        reset      = 1'b0;
        start_r[0] = 1'b0;
        @(negedge bitclk);
        check_idle(0, 1'b0);

        for (int v = 0; v < 9; v++) begin
            cur = vecs[v].name;
            run_frame(vecs[v].sel, vecs[v].data, vecs[v].exp, vecs[v].cpb);
        end

        // Start held high: two frames with one idle cycle between them.
        cur        = "back_to_back";
        data_b     = 8'h55;
        start_r[0] = 1'b1;
        @(negedge bitclk);
        data_b     = 8'h0F;
        check_frame(0, "01010101011111", 1, 1'b0);
        @(negedge bitclk);
        start_r[0] = 1'b0;
        check_frame(0, "01111000011111", 1, 1'b0);
        @(negedge bitclk);
        check_idle(0, 1'b0);

        // Reset during data bit 3 aborts the frame without done.
        cur        = "reset_mid_frame";
        data_b     = 8'hA5;
        start_r[0] = 1'b1;
        @(negedge bitclk);
        start_r[0] = 1'b0;
        repeat (4) @(negedge bitclk);
        check("mid_state", 32'(st_w[0]), 2);
        check("mid_bitcnt", 32'(bc_w[0]), 3);
        check("mid_tx", 32'(tx_w[0]), 0);
        reset = 1'b1;
        @(negedge bitclk);
        check_idle(0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge bitclk);
            check("no_done", 32'(done_w[0]), 0);
            check("stay_idle", 32'(bsy_w[0]), 0);
        end
        cur = "after_reset_3C";
        run_frame(0, 8'h3C, "00011110011111", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
